// File: rtl/pkt_inspect_pkg.sv
// Shared types and helpers for the packet inspection buffer and its pattern matcher.
package pkt_inspect_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_HOLD,
        ST_TX,
        ST_DISCARD
    } state_e;

    localparam logic [1:0] CMD_RELEASE = 2'b01;
    localparam logic [1:0] CMD_DROP    = 2'b10;

    // A non-zero ctrl word only closes a packet once its payload has started.
    function automatic logic is_last(input logic ctrl_nonzero, input logic in_payload);
        return ctrl_nonzero && in_payload;
    endfunction

endpackage

// File: rtl/pkt_pattern_match.sv
// Per-word comparator array against NUM_PATTERNS byte-masked patterns, with sticky per-packet hit flags.
module pkt_pattern_match
    import pkt_inspect_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int CTRL_WIDTH   = DATA_WIDTH / 8,
    parameter int NUM_PATTERNS = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear_i,
    input  logic                               en_i,
    input  logic [DATA_WIDTH-1:0]              data_i,
    input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] pattern_data_i,
    input  logic [NUM_PATTERNS*CTRL_WIDTH-1:0] pattern_mask_i,
    output logic [NUM_PATTERNS-1:0]            flags_o
);

    logic [NUM_PATTERNS-1:0] hit;
    logic [NUM_PATTERNS-1:0] flags_q;

    // An all-zero mask starts the pattern as a miss, which disables it.
    always_comb begin
        hit = '0;
        for (int p = 0; p < NUM_PATTERNS; p++) begin
            hit[p] = |pattern_mask_i[p*CTRL_WIDTH +: CTRL_WIDTH];
            for (int b = 0; b < CTRL_WIDTH; b++) begin
                if (pattern_mask_i[p*CTRL_WIDTH + b] &&
                    data_i[b*BYTE_W +: BYTE_W] != pattern_data_i[p*DATA_WIDTH + b*BYTE_W +: BYTE_W])
                    hit[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            flags_q <= '0;
        else if (clear_i)
            flags_q <= '0;
        else if (en_i)
            flags_q <= flags_q | hit;
    end

    assign flags_o = flags_q;

endmodule

// File: rtl/pkt_inspect_buffer.sv
// Single-packet store-and-inspect buffer: CPU hold/modify/release (MODE=0) or automatic drop-on-match (MODE=1).
module pkt_inspect_buffer
    import pkt_inspect_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int CTRL_WIDTH   = DATA_WIDTH / 8,
    parameter int DEPTH_BITS   = 8,
    parameter int NUM_PATTERNS = 4,
    parameter int MODE         = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic [CTRL_WIDTH-1:0]              in_ctrl,
    input  logic                               in_wr,
    output logic                               in_rdy,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [CTRL_WIDTH-1:0]              out_ctrl,
    output logic                               out_wr,
    input  logic                               out_rdy,
    input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] pattern_data,
    input  logic [NUM_PATTERNS*CTRL_WIDTH-1:0] pattern_mask,
    input  logic                               cpu_cmd_valid,
    input  logic [1:0]                         cpu_cmd,
    input  logic [DEPTH_BITS-1:0]              cpu_addr,
    input  logic                               cpu_wr_en,
    input  logic [CTRL_WIDTH+DATA_WIDTH-1:0]   cpu_wr_data,
    output logic [CTRL_WIDTH+DATA_WIDTH-1:0]   cpu_rd_data,
    output logic                               held_valid,
    output logic [DEPTH_BITS:0]                held_len,
    output logic [NUM_PATTERNS-1:0]            held_match,
    output logic [31:0]                        match_count,
    output logic [31:0]                        drop_count
);

    localparam int                  WORD_W  = CTRL_WIDTH + DATA_WIDTH;
    localparam int                  DEPTH   = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] PTR_ONE = (DEPTH_BITS+1)'(1);
    localparam logic [DEPTH_BITS:0] FULL    = {1'b1, {DEPTH_BITS{1'b0}}};

    state_e                  state_q, state_d;
    logic [DEPTH_BITS:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, held_len_q, held_len_d;
    logic                    in_payload_q, in_payload_d;
    logic [31:0]             match_count_q, match_count_d, drop_count_q, drop_count_d;
    logic                    out_wr_q, out_wr_d;
    logic                    skid_valid_q, skid_valid_d;
    logic [WORD_W-1:0]       skid_word_q, rd_word_q;
    logic                    rd_oob_q;
    logic [WORD_W-1:0]       mem [DEPTH];

    logic                    accepting, eff_wr, ctrl_nz, last, cpu_in_range;
    logic [WORD_W-1:0]       eff_word, mem_wdata;
    logic [DEPTH_BITS-1:0]   mem_waddr, rd_addr;
    logic                    mem_we, match_en, match_clear;
    logic [NUM_PATTERNS-1:0] match_flags;

    // The one word upstream may still send after in_rdy drops is parked and replayed on return to IDLE.
    assign accepting    = (state_q == ST_IDLE) || (state_q == ST_RX) || (state_q == ST_DISCARD);
    assign in_rdy       = accepting && !skid_valid_q;
    assign eff_wr       = accepting && (skid_valid_q || in_wr);
    assign eff_word     = skid_valid_q ? skid_word_q : {in_ctrl, in_data};
    assign ctrl_nz      = |eff_word[WORD_W-1:DATA_WIDTH];
    assign last         = is_last(ctrl_nz, in_payload_q);
    assign cpu_in_range = {1'b0, cpu_addr} < held_len_q;
    assign skid_valid_d = accepting ? 1'b0 : (skid_valid_q || in_wr);

    pkt_pattern_match #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CTRL_WIDTH  (CTRL_WIDTH),
        .NUM_PATTERNS(NUM_PATTERNS)
    ) u_match (
        .clk           (clk),
        .reset         (reset),
        .clear_i       (match_clear),
        .en_i          (match_en),
        .data_i        (eff_word[DATA_WIDTH-1:0]),
        .pattern_data_i(pattern_data),
        .pattern_mask_i(pattern_mask),
        .flags_o       (match_flags)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        held_len_d    = held_len_q;
        in_payload_d  = in_payload_q;
        match_count_d = match_count_q;
        drop_count_d  = drop_count_q;
        out_wr_d      = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = wr_ptr_q[DEPTH_BITS-1:0];
        mem_wdata     = eff_word;
        match_en      = 1'b0;
        match_clear   = 1'b0;
        rd_addr       = cpu_addr;
        unique case (state_q)
            ST_IDLE: begin
                if (eff_wr && ctrl_nz) begin
                    mem_we       = 1'b1;
                    mem_waddr    = '0;
                    wr_ptr_d     = PTR_ONE;
                    in_payload_d = 1'b0;
                    match_clear  = 1'b1;
                    state_d      = ST_RX;
                end
            end
            ST_RX: begin
                if (eff_wr) begin
                    if (!ctrl_nz) in_payload_d = 1'b1;
                    if (wr_ptr_q == FULL) begin
                        if (last) begin
                            drop_count_d = drop_count_q + 32'd1;
                            state_d      = ST_IDLE;
                        end else begin
                            state_d = ST_DISCARD;
                        end
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        match_en = !ctrl_nz;
                        if (last) begin
                            held_len_d = wr_ptr_q + PTR_ONE;
                            if (|match_flags) match_count_d = match_count_q + 32'd1;
                            rd_ptr_d = '0;
                            if (MODE == 0) begin
                                state_d = ST_HOLD;
                            end else if (|match_flags) begin
                                drop_count_d = drop_count_q + 32'd1;
                                state_d      = ST_IDLE;
                            end else begin
                                state_d = ST_TX;
                            end
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (eff_wr) begin
                    if (!ctrl_nz) in_payload_d = 1'b1;
                    if (last) begin
                        drop_count_d = drop_count_q + 32'd1;
                        state_d      = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (cpu_wr_en && cpu_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = cpu_addr;
                    mem_wdata = cpu_wr_data;
                end
                if (cpu_cmd_valid && cpu_cmd == CMD_RELEASE) begin
                    rd_ptr_d = '0;
                    state_d  = ST_TX;
                end else if (cpu_cmd_valid && cpu_cmd == CMD_DROP) begin
                    drop_count_d = drop_count_q + 32'd1;
                    state_d      = ST_IDLE;
                end
            end
            ST_TX: begin
                rd_addr = rd_ptr_q[DEPTH_BITS-1:0];
                // Stay one extra cycle so the final out_wr pulse is still inside TX.
                if (rd_ptr_q == held_len_q) begin
                    state_d = ST_IDLE;
                end else if (out_rdy) begin
                    out_wr_d = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            held_len_q    <= '0;
            in_payload_q  <= 1'b0;
            match_count_q <= '0;
            drop_count_q  <= '0;
            out_wr_q      <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_word_q   <= '0;
            rd_word_q     <= '0;
            rd_oob_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            held_len_q    <= held_len_d;
            in_payload_q  <= in_payload_d;
            match_count_q <= match_count_d;
            drop_count_q  <= drop_count_d;
            out_wr_q      <= out_wr_d;
            skid_valid_q  <= skid_valid_d;
            if (!accepting && in_wr && !skid_valid_q) skid_word_q <= {in_ctrl, in_data};
            rd_word_q     <= mem[rd_addr];
            rd_oob_q      <= !cpu_in_range;
        end
    end

    // NOTE: the packet store has no reset; pointers and held_len guard every read of stale contents.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign out_wr                = out_wr_q;
    assign {out_ctrl, out_data}  = out_wr_q ? rd_word_q : '0;
    assign cpu_rd_data           = rd_oob_q ? '0 : rd_word_q;
    assign held_valid            = (state_q == ST_HOLD);
    assign held_len              = held_len_q;
    assign held_match            = match_flags;
    assign match_count           = match_count_q;
    assign drop_count            = drop_count_q;

endmodule

// File: tb/tb_pkt_inspect_buffer.sv
// Directed self-checking bench: one CPU-hold instance and one auto-drop instance, both with a 16-word store.
module tb_pkt_inspect_buffer;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int DB = 4;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [DW-1:0]    in_data;
    logic [CW-1:0]    in_ctrl;
    logic             wr_h, wr_a, out_rdy;
    logic [NP*DW-1:0] pattern_data;
    logic [NP*CW-1:0] pattern_mask;
    logic             cpu_cmd_valid, cpu_wr_en;
    logic [1:0]       cpu_cmd;
    logic [DB-1:0]    cpu_addr;
    logic [CW+DW-1:0] cpu_wr_data;

    logic [DW-1:0] h_out_data, a_out_data;
    logic [CW-1:0] h_out_ctrl, a_out_ctrl;
    logic          h_in_rdy, a_in_rdy, h_out_wr, a_out_wr, h_held_valid, a_held_valid;
    logic [CW+DW-1:0] h_cpu_rd_data, a_cpu_rd_data;
    logic [DB:0]   h_held_len, a_held_len;
    logic [NP-1:0] h_held_match, a_held_match;
    logic [31:0]   h_match_count, a_match_count, h_drop_count, a_drop_count;

    pkt_inspect_buffer #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEPTH_BITS(DB), .NUM_PATTERNS(NP), .MODE(0)) u_hold (
        .clk(clk), .reset(rst_n), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(wr_h), .in_rdy(h_in_rdy),
        .out_data(h_out_data), .out_ctrl(h_out_ctrl), .out_wr(h_out_wr), .out_rdy(out_rdy),
        .pattern_data(pattern_data), .pattern_mask(pattern_mask),
        .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wr_en(cpu_wr_en),
        .cpu_wr_data(cpu_wr_data), .cpu_rd_data(h_cpu_rd_data), .held_valid(h_held_valid),
        .held_len(h_held_len), .held_match(h_held_match), .match_count(h_match_count), .drop_count(h_drop_count)
    );

    pkt_inspect_buffer #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEPTH_BITS(DB), .NUM_PATTERNS(NP), .MODE(1)) u_auto (
        .clk(clk), .reset(rst_n), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(wr_a), .in_rdy(a_in_rdy),
        .out_data(a_out_data), .out_ctrl(a_out_ctrl), .out_wr(a_out_wr), .out_rdy(out_rdy),
        .pattern_data(pattern_data), .pattern_mask(pattern_mask),
        .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wr_en(cpu_wr_en),
        .cpu_wr_data(cpu_wr_data), .cpu_rd_data(a_cpu_rd_data), .held_valid(a_held_valid),
        .held_len(a_held_len), .held_match(a_held_match), .match_count(a_match_count), .drop_count(a_drop_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int h_bad    = 0;
    logic prev_rdy = 1'b1;
    logic [CW+DW-1:0] h_q[$];
    logic [CW+DW-1:0] a_q[$];
    logic [7:0]  pc[32];
    logic [63:0] pd[32];

    // Output words are collected on the falling edge; an out_wr not preceded by out_rdy counts as bad.
    always @(negedge clk) begin
        if (h_out_wr) begin
            h_q.push_back({h_out_ctrl, h_out_data});
            if (!prev_rdy) h_bad++;
        end
        if (a_out_wr) a_q.push_back({a_out_ctrl, a_out_data});
        prev_rdy = out_rdy;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic build(input int n, input logic [31:0] base, input logic [7:0] last_c);
        for (int i = 0; i < n; i++) begin
            pc[i] = (i == 0) ? 8'hFF : ((i == n - 1) ? last_c : 8'h00);
            pd[i] = {base, 32'(i)};
        end
    endtask

    task automatic send(input bit to_auto, input int n);
        for (int i = 0; i < n; i++) begin
            in_ctrl = pc[i];
            in_data = pd[i];
            if (to_auto) wr_a = 1'b1; else wr_h = 1'b1;
            tick(1);
        end
        wr_a = 1'b0; wr_h = 1'b0; in_ctrl = '0; in_data = '0;
    endtask

    task automatic command(input logic [1:0] cmd);
        cpu_cmd_valid = 1'b1; cpu_cmd = cmd;
        tick(1);
        cpu_cmd_valid = 1'b0; cpu_cmd = 2'b00;
    endtask

    task automatic expect_out(input bit from_auto, input int n, input string tag);
        int sz;
        sz = from_auto ? a_q.size() : h_q.size();
        check({tag, "_count"}, 128'(sz), 128'(n));
        for (int i = 0; i < n && i < sz; i++)
            check($sformatf("%s_w%0d", tag, i), from_auto ? a_q[i] : h_q[i], {pc[i], pd[i]});
        a_q.delete(); h_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_h_in_rdy"}, h_in_rdy, 1);
        check({tag, "_a_in_rdy"}, a_in_rdy, 1);
        check({tag, "_h_out_wr"}, h_out_wr, 0);
        check({tag, "_h_held_valid"}, h_held_valid, 0);
        check({tag, "_h_held_len"}, h_held_len, 0);
        check({tag, "_h_held_match"}, h_held_match, 0);
        check({tag, "_h_match_count"}, h_match_count, 0);
        check({tag, "_h_drop_count"}, h_drop_count, 0);
        check({tag, "_a_match_count"}, a_match_count, 0);
        check({tag, "_a_drop_count"}, a_drop_count, 0);
        check({tag, "_h_cpu_rd"}, h_cpu_rd_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        in_data = '0; in_ctrl = '0; wr_h = 1'b0; wr_a = 1'b0; out_rdy = 1'b1;
        cpu_cmd_valid = 1'b0; cpu_cmd = 2'b00; cpu_addr = '0; cpu_wr_en = 1'b0; cpu_wr_data = '0;
        pattern_data = '0; pattern_mask = '0;
        pattern_data[63:0]    = {32'h1111, 32'd2};
        pattern_mask[7:0]     = 8'hFF;
        pattern_data[127:64]  = {32'h1111, 32'd3};
        pattern_data[255:192] = {32'h0, 32'hCAFE_BABE};
        tick(2);
        check_reset_state("reset");
        rst_n = 1'b1;
        tick(1);

        // Hold, read back, release five words; pattern1 has a zero mask and must stay silent.
        build(5, 32'h1111, 8'h04);
        send(0, 5);
        check("p1_held_valid", h_held_valid, 1);
        check("p1_held_len", h_held_len, 5);
        check("p1_held_match", h_held_match, 4'b0001);
        check("p1_match_count", h_match_count, 1);
        check("p1_in_rdy_low", h_in_rdy, 0);
        cpu_addr = 4'd4;
        tick(1);
        check("p1_cpu_rd4", h_cpu_rd_data, {pc[4], pd[4]});
        command(2'b01);
        tick(10);
        expect_out(0, 5, "p1_out");
        check("p1_idle_in_rdy", h_in_rdy, 1);
        check("p1_match_stable", h_held_match, 4'b0001);

        // Modify word 2 in HOLD, probe out-of-range reads and writes, then release.
        build(5, 32'h2222, 8'h04);
        send(0, 5);
        check("p2_held_match", h_held_match, 4'b0000);
        check("p2_match_count", h_match_count, 1);
        cpu_addr = 4'd2; cpu_wr_en = 1'b1; cpu_wr_data = {8'h00, 64'hDEAD};
        tick(1);
        cpu_wr_en = 1'b0;
        tick(1);
        check("p2_cpu_rd2", h_cpu_rd_data, {8'h00, 64'hDEAD});
        cpu_addr = 4'd7; cpu_wr_en = 1'b1; cpu_wr_data = '1;
        tick(1);
        cpu_wr_en = 1'b0;
        tick(1);
        check("p2_cpu_rd7", h_cpu_rd_data, 0);
        cpu_addr = 4'd5;
        tick(1);
        check("p2_cpu_rd5", h_cpu_rd_data, 0);
        pd[2] = 64'hDEAD;
        command(2'b01);
        tick(10);
        expect_out(0, 5, "p2_out");

        // Ignored command code, then CPU drop.
        build(3, 32'h3333, 8'h01);
        send(0, 3);
        command(2'b11);
        check("p3_cmd11_ignored", h_held_valid, 1);
        command(2'b10);
        tick(5);
        check("p3_drop_count", h_drop_count, 1);
        check("p3_held_valid", h_held_valid, 0);
        check("p3_no_output", 128'(h_q.size()), 0);

        // Auto mode: clean packet forwarded, packet hitting pattern3 (low four bytes) dropped.
        pattern_mask[31:24] = 8'h0F;
        build(4, 32'h4444, 8'h01);
        send(1, 4);
        tick(8);
        expect_out(1, 4, "a1_out");
        check("a1_drop_count", a_drop_count, 0);
        build(4, 32'h5555, 8'h01);
        pd[1] = 64'h1234_5678_CAFE_BABE;
        send(1, 4);
        tick(8);
        check("a2_no_output", 128'(a_q.size()), 0);
        check("a2_drop_count", a_drop_count, 1);
        check("a2_match_count", a_match_count, 1);
        check("a2_held_match", a_held_match, 4'b1000);

        // 20-word packet into a 16-word store, then a short packet must pass intact.
        build(20, 32'h6666, 8'h01);
        send(0, 20);
        tick(3);
        check("ovf_drop_count", h_drop_count, 2);
        check("ovf_held_valid", h_held_valid, 0);
        check("ovf_no_output", 128'(h_q.size()), 0);
        check("ovf_in_rdy", h_in_rdy, 1);
        build(3, 32'h7777, 8'h02);
        send(0, 3);
        check("post_ovf_len", h_held_len, 3);
        command(2'b01);
        tick(8);
        expect_out(0, 3, "post_ovf_out");

        // Alternate out_rdy every cycle during TX of an 8-word packet.
        build(8, 32'h8888, 8'hF0);
        send(0, 8);
        command(2'b01);
        for (int i = 0; i < 30; i++) begin
            out_rdy = ~out_rdy;
            tick(1);
        end
        out_rdy = 1'b1;
        tick(4);
        expect_out(0, 8, "stall_out");
        check("stall_wr_without_rdy", 128'(h_bad), 0);

        // Asynchronous reset in the middle of RX.
        build(6, 32'h9999, 8'h01);
        send(0, 3);
        #2 rst_n = 1'b0;
        #1 check_reset_state("midrx");
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(3);
        check("midrx_no_output", 128'(h_q.size()), 0);
        build(3, 32'hAAAA, 8'h02);
        send(0, 3);
        check("post_rst_held_valid", h_held_valid, 1);
        check("post_rst_len", h_held_len, 3);
        command(2'b01);
        tick(8);
        expect_out(0, 3, "post_rst_out");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
